ifetch_pipe: RTL

Parametrised, pipelined instruction-fetch stage for the next-generation CPU core. Issues sequential fetches to a synchronous instruction memory, buffers returned instructions with their PCs in a small prefetch queue, and hands them to decode over a valid/ready handshake. A redirect input from the branch/jump resolution stage flushes all fetched-but-unconsumed work and restarts fetch at a new target.

---
 rtl/ifetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 52 +++++
 rtl/ifetch_pipe.sv | 94 +++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Contents: default address/data widths, default reset PC, the number of
//           instruction-word alignment bits, and the prefetch queue entry type.
package ifetch_pkg;

  localparam int unsigned IF_ADDR_W       = 32;
  localparam int unsigned IF_DATA_W       = 32;
  localparam logic [31:0] IF_RESET_PC     = 32'h0000_0000;
  // Instructions are 4-byte words: the two LSBs of any fetch address are 0.
  localparam int unsigned WORD_ALIGN_BITS = 2;

  // One prefetch queue entry at the default widths.
  typedef struct packed {
    logic [IF_ADDR_W-1:0] pc;
    logic [IF_DATA_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO, DEPTH entries of WIDTH bits.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   push, wdata   write an entry (caller guarantees room, counting same-cycle pop)
//   pop, rdata    remove the head entry; rdata always shows the head
//   flush         empty the FIFO; dominant over push and pop
//   count         number of valid entries, 0..DEPTH
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // DEPTH is a power of two, so the pointers wrap at DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/ifetch_pipe.sv
// Pipelined instruction-fetch stage.
// Issues sequential word fetches to a synchronous instruction memory (data
// one cycle after the request), queues {pc, inst} pairs and presents the
// head to decode over a valid/ready handshake. Redirect flushes all fetched
// but unconsumed work and restarts fetch at Redirect_PC in the same cycle.
// Ports:
//   Clk, Rst_n             clock, asynchronous active-low reset
//   Redirect, Redirect_PC  flush and restart target (bits [1:0] ignored)
//   Imem_req, Imem_addr    fetch request / word-aligned address
//   Imem_rdata             instruction for the previous cycle's request
//   Inst, Inst_PC          head-of-queue instruction and its PC (0 if invalid)
//   Inst_valid, Inst_ready decode handshake
module ifetch_pipe import ifetch_pkg::*; #(
  parameter int unsigned       ADDR_W   = IF_ADDR_W,
  parameter int unsigned       DATA_W   = IF_DATA_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] Redirect_PC,
  output logic              Imem_req,
  output logic [ADDR_W-1:0] Imem_addr,
  input  logic [DATA_W-1:0] Imem_rdata,
  output logic [DATA_W-1:0] Inst,
  output logic [ADDR_W-1:0] Inst_PC,
  output logic              Inst_valid,
  input  logic              Inst_ready
);

  localparam int unsigned       CW         = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << WORD_ALIGN_BITS) - 1);
  localparam logic [CW:0]       DEPTH_L    = (CW + 1)'(DEPTH);

  logic [ADDR_W-1:0]        fpc;
  logic [ADDR_W-1:0]        tag_pc;
  logic                     inflight;
  logic [ADDR_W-1:0]        redirect_addr;
  logic                     pop;
  logic                     push;
  logic [CW-1:0]            count;
  logic [CW:0]              occupancy;
  logic [CW:0]              limit;
  logic [ADDR_W+DATA_W-1:0] head;

  always_comb begin
    redirect_addr = Redirect_PC & ~ALIGN_MASK;
    Inst_valid    = Rst_n & (count != '0);
    pop           = Inst_valid & Inst_ready & ~Redirect;
    // A response arriving in a redirect cycle belongs to the old stream.
    push          = inflight & ~Redirect;
    // count + inflight - pop < DEPTH, rearranged to stay unsigned.
    occupancy     = {1'b0, count} + (CW + 1)'(inflight);
    limit         = DEPTH_L + (CW + 1)'(pop);
    // A redirect empties the queue and drops the in-flight slot, so it
    // always has credit for its own request.
    Imem_req      = Rst_n & (Redirect | (occupancy < limit));
    if (!Rst_n)        Imem_addr = RESET_PC;
    else if (Redirect) Imem_addr = redirect_addr;
    else               Imem_addr = fpc;
    Inst          = Inst_valid ? head[DATA_W-1:0] : '0;
    Inst_PC       = Inst_valid ? head[ADDR_W+DATA_W-1:DATA_W] : '0;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fpc      <= RESET_PC;
      tag_pc   <= '0;
      inflight <= 1'b0;
    end else if (Imem_req) begin
      fpc      <= Imem_addr + ADDR_W'(4);
      tag_pc   <= Imem_addr;
      inflight <= 1'b1;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst_n (Rst_n),
    .push  (push),
    .pop   (pop),
    .flush (Redirect),
    .wdata ({tag_pc, Imem_rdata}),
    .rdata (head),
    .count (count)
  );

endmodule
